// File: rtl/stereo_cam_sim_pkg.sv
// stereo_sim_pkg: raster FSM state encoding and test-pattern mode codes shared by the stereo camera simulator
package stereo_sim_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_VBLANK} state_t;
  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_FRAMEID = 2'd3;
endpackage

// File: rtl/stereo_cam_sim_if.sv
// stereo_cam_sim_if: pixel stream bus (pclk, value, x, y, is_val, frame_start, line_end, frame_cnt, busy); master drives, slave consumes
interface stereo_cam_sim_if #(
  parameter int NUM_CAM = 2,
  parameter int PIX_W = 8,
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic pclk;
  logic [NUM_CAM*PIX_W-1:0] value;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic is_val;
  logic frame_start;
  logic line_end;
  logic [7:0] frame_cnt;
  logic busy;
  modport master(output pclk, value, x, y, is_val, frame_start, line_end, frame_cnt, busy);
  modport slave(input pclk, value, x, y, is_val, frame_start, line_end, frame_cnt, busy);
endinterface

// File: rtl/stereo_cam_sim_pattern.sv
// cam_pattern_gen: combinational per-camera pixel value from (x, y, frame_cnt, mode, const_val) with camera disparity shift -> pix
module cam_pattern_gen
  import stereo_sim_pkg::*;
#(
  parameter int CAM = 0,
  parameter int PIX_W = 8,
  parameter int WIDTH = 640,
  parameter int DISP = 4,
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [7:0]       frame_cnt,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] const_val,
  output logic [PIX_W-1:0] pix
);
  localparam int OFF = (CAM * DISP) % WIDTH;
  logic [X_W:0] s;
  logic [X_W:0] xc;
  always_comb begin
    s = {1'b0, x} + (X_W+1)'(OFF);
    xc = s >= (X_W+1)'(WIDTH) ? s - (X_W+1)'(WIDTH) : s;
    pix = mode == MODE_RAMP ? PIX_W'(xc) + PIX_W'(y) + PIX_W'(frame_cnt)
        : mode == MODE_CHECKER ? {PIX_W{xc[3] ^ y[3]}}
        : mode == MODE_CONST ? const_val
        : PIX_W'(frame_cnt);
  end
endmodule

// File: rtl/stereo_cam_sim.sv
// stereo_cam_sim: multi-camera raster source; clk, reset (sync active-low), go, mode, const_val in; pix stream bus out
module stereo_cam_sim
  import stereo_sim_pkg::*;
#(
  parameter int NUM_CAM = 2,
  parameter int PIX_W = 8,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int HBLANK = 160,
  parameter int VBLANK = 45,
  parameter int PCLK_DIV = 2,
  parameter int DISP = 4,
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] const_val,
  stereo_cam_sim_if.master pix
);
  localparam int H_TOT = WIDTH + HBLANK;
  localparam int V_TOT = HEIGHT + VBLANK;
  localparam int DIV_W = PCLK_DIV > 1 ? $clog2(PCLK_DIV) : 1;
  state_t state, state_n;
  logic [X_W-1:0] h, h_n;
  logic [Y_W-1:0] v, v_n;
  logic [DIV_W-1:0] div, div_n;
  logic [1:0] mode_q, mode_n;
  logic [7:0] fc, fc_n;
  logic slot, act, last_h, last_v, eof, start;
  logic [NUM_CAM*PIX_W-1:0] pat;
  for (genvar c = 0; c < NUM_CAM; c++) begin : g_cam
    cam_pattern_gen #(
      .CAM(c), .PIX_W(PIX_W), .WIDTH(WIDTH), .DISP(DISP), .X_W(X_W), .Y_W(Y_W)
    ) u_pat (
      .x(h), .y(v), .frame_cnt(fc), .mode(mode_q), .const_val(const_val),
      .pix(pat[c*PIX_W +: PIX_W])
    );
  end
  always_comb begin
    slot = state != ST_IDLE && div == '0;
    act = slot && state == ST_ACTIVE;
    last_h = h == X_W'(H_TOT - 1);
    last_v = v == Y_W'(V_TOT - 1);
    eof = slot && last_h && last_v;
    start = state == ST_IDLE && go;
    div_n = state == ST_IDLE || div == DIV_W'(PCLK_DIV - 1) ? '0 : div + 1'b1;
    h_n = slot ? (last_h ? '0 : h + 1'b1) : h;
    v_n = slot && last_h ? (last_v ? '0 : v + 1'b1) : v;
    fc_n = eof ? fc + 1'b1 : fc;
    mode_n = start || (eof && go) ? mode : mode_q;
    state_n = state == ST_IDLE ? (go ? ST_ACTIVE : ST_IDLE)
            : !slot ? state
            : eof && !go ? ST_IDLE
            : v_n >= Y_W'(HEIGHT) ? ST_VBLANK
            : h_n >= X_W'(WIDTH) ? ST_HBLANK
            : ST_ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      h <= '0;
      v <= '0;
      div <= '0;
      mode_q <= MODE_RAMP;
      fc <= '0;
      pix.pclk <= 1'b0;
      pix.value <= '0;
      pix.x <= '0;
      pix.y <= '0;
      pix.is_val <= 1'b0;
      pix.frame_start <= 1'b0;
      pix.line_end <= 1'b0;
      pix.busy <= 1'b0;
    end else begin
      state <= state_n;
      h <= h_n;
      v <= v_n;
      div <= div_n;
      mode_q <= mode_n;
      fc <= fc_n;
      pix.pclk <= slot;
      pix.is_val <= act;
      pix.frame_start <= act && h == '0 && v == '0;
      pix.line_end <= act && h == X_W'(WIDTH - 1);
      pix.busy <= state_n != ST_IDLE;
      if (act) begin
        pix.x <= h;
        pix.y <= v;
        pix.value <= pat;
      end
    end
  end
  assign pix.frame_cnt = fc;
endmodule

// File: doc/stereo_cam_sim.md
Name: stereo_cam_sim

Overview:
Parametrised synthetic multi-camera pixel source for simulation and bring-up. It is the successor to the single-camera simulator. It emits NUM_CAM lock-stepped raster streams with programmable frame size, blanking, pixel rate, test-pattern mode and per-camera horizontal disparity. It feeds the VGA/frame-buffer path and the stereo matcher through the existing value/x/y/is_val pixel interface.

Parameters:
NUM_CAM, 2, number of camera channels packed on value
PIX_W, 8, bits per pixel per camera
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
HBLANK, 160, blank pixel slots per line (>=1)
VBLANK, 45, blank lines per frame (>=1)
PCLK_DIV, 2, clk cycles per pixel slot (>=1)
DISP, 4, horizontal shift per camera index, in pixels (DISP < WIDTH)
X_W, 10, width of x (must be >= clog2(WIDTH+HBLANK))
Y_W, 10, width of y (must be >= clog2(HEIGHT+VBLANK))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
go  in  1  level; start/continue frames
mode  in  2  pattern select; sampled at frame start only
const_val  in  PIX_W  pixel value for CONST mode
pclk  out  1  one-clk pixel-slot strobe
value  out  NUM_CAM*PIX_W  cam c occupies bits [c*PIX_W +: PIX_W]
x  out  X_W  column of current pixel
y  out  Y_W  line of current pixel
is_val  out  1  value/x/y carry an active pixel this cycle
frame_start  out  1  high with is_val for pixel (0,0)
line_end  out  1  high with is_val for pixel (WIDTH-1, y)
frame_cnt  out  8  completed-frame counter, wraps 255->0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; all outputs 0, including value, x, y, frame_cnt and the latched mode. Reset has priority over everything and aborts a frame mid-line with no partial flush.
- States:
  - IDLE: go==1 moves to ACTIVE with h=0 and v=0, and latches mode.
  - ACTIVE: h<WIDTH and v<HEIGHT.
  - HBLANK: WIDTH<=h<WIDTH+HBLANK and v<HEIGHT.
  - VBLANK: v>=HEIGHT.
- Raster counters h and v advance only on pclk slots.
  - h wraps at WIDTH+HBLANK-1 to 0, and v increments on that wrap.
  - v wraps at HEIGHT+VBLANK-1 to 0, and frame_cnt increments on that wrap.
- End of frame, at the last VBLANK slot:
  - go==1: continue at (0,0) and re-latch mode.
  - go==0: enter IDLE.
  - Deasserting go mid-frame never truncates the frame.
- pclk strobes:
  - Strobes once every PCLK_DIV clk cycles while busy. pclk is constant 1 when PCLK_DIV==1.
  - The divider resets on leaving IDLE, so the first strobe occurs on the edge after go is sampled.
  - pclk is 0 in IDLE.
- Output timing:
  - All outputs are registered.
  - On a strobe cycle in ACTIVE: is_val=1, x=h, y=v, and value is computed for (h,v).
  - In every other cycle: is_val, frame_start and line_end are 0; x, y and value hold their last values.
- Latency: with go sampled at edge N, pixel (0,0) appears after edge N+1. Pixel k of the frame appears after edge N+1+PCLK_DIV*k', where k' is the slot index including blank slots.
- Frame length is (WIDTH+HBLANK)*(HEIGHT+VBLANK)*PCLK_DIV clk cycles.
- Per-camera pattern: xc = (x + c*DISP) mod WIDTH. All arithmetic is unsigned and truncated to PIX_W.
  - mode 0, RAMP: xc + y + frame_cnt.
  - mode 1, CHECKER: all ones if (xc[3] ^ y[3]), else 0.
  - mode 2, CONST: const_val for every camera, with no disparity.
  - mode 3, FRAMEID: frame_cnt[PIX_W-1:0] for every camera (zero-extended if PIX_W>8).
- Simultaneous events:
  - A mode change mid-frame is ignored until the next frame start.
  - go toggling during VBLANK is evaluated only at the last VBLANK slot.

Decomposition:
- Shared package stereo_sim_pkg:
  - state encoding (IDLE/ACTIVE/HBLANK/VBLANK);
  - mode constants MODE_RAMP=0, MODE_CHECKER=1, MODE_CONST=2, MODE_FRAMEID=3.
- Sub-module cam_pattern_gen: one instance per camera via generate loop, with the camera index as a parameter. It is combinational in (x, y, frame_cnt, mode, const_val) and feeds the registered value slice.
- The top level holds the divider, raster counters, FSM and output registers.

Test Plan:
All scenarios use NUM_CAM=2, PIX_W=8, WIDTH=4, HEIGHT=3, HBLANK=2, VBLANK=1, PCLK_DIV=2, DISP=1.
1. Reset, then go=1, mode=RAMP → first is_val one cycle after go is sampled, with (x,y)=(0,0), frame_start=1 and value={8'd1,8'd0}. Pixel (3,0) gives value={8'd0,8'd3} (cam1 wraps) and line_end=1. 12 is_val pulses per frame; frame period is 48 clk.
2. Continuous go for 3 frames → frame_cnt steps 0,1,2,3 at the end of each 48-clk frame. Frame 2 pixel (1,2) has cam0 = 1+2+2 = 5. pclk is high exactly every 2nd clk.
3. Drop go at pixel (1,1) → the frame completes all 12 pixels, then busy=0 and pclk=0 with no further is_val. frame_cnt=1.
4. mode=CONST with const_val=8'hA5, switched to CHECKER mid-frame → every pixel of that frame shows {A5,A5}. The next frame shows the checker pattern, all 0 for this 4x3 size since xc[3]=0 and y[3]=0.
5. Assert reset (0) during HBLANK of line 1 → next cycle all outputs are 0 and the block is in IDLE. After release with go=1, the stream restarts at (0,0) with frame_cnt=0.
6. PCLK_DIV=1, mode=FRAMEID → is_val high for 4 consecutive clk, then 2 low, per line. value={frame_cnt,frame_cnt}.
